// File: rtl/counter_ctrl.sv
// Sequencer for a loadable up-counter: loads a start value, counts up to an end
// value, pulses tick once per completed run, and optionally reloads for periodic runs.
module counter_ctrl #(
  parameter int W      = 8,
  parameter int RUNS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              periodic,
  input  logic [W-1:0]      start_val,
  input  logic [W-1:0]      end_val,
  input  logic [W-1:0]      count,
  output logic [W-1:0]      load,
  output logic              le,
  output logic              ce,
  output logic              busy,
  output logic              tick,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    TICK = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [W-1:0]        start_q_reg;
  logic [W-1:0]        end_q_reg;
  logic                periodic_q_reg;
  logic [RUNS_W-1:0]   runs_reg;
  logic                accept;

  assign accept = (state_reg == IDLE) && start && !stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      start_q_reg    <= '0;
      end_q_reg      <= '0;
      periodic_q_reg <= 1'b0;
      runs_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        start_q_reg    <= start_val;
        end_q_reg      <= end_val;
        periodic_q_reg <= periodic;
        runs_reg       <= '0;
      end else if (state_reg == TICK) begin
        // The tick of this cycle has already been emitted, so a concurrent stop still counts it.
        runs_reg <= runs_reg + RUNS_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    le         = 1'b0;
    ce         = 1'b0;
    busy       = 1'b1;
    tick       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        le         = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        ce = (count != end_q_reg);
        if (count == end_q_reg) state_next = TICK;
      end
      TICK: begin
        tick       = 1'b1;
        state_next = periodic_q_reg ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort only redirects the next state; this cycle's outputs stand.
    if (stop && (state_reg != IDLE)) state_next = IDLE;
  end

  assign load = start_q_reg;
  assign runs = runs_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl driving a behavioural registered up-counter (W=8):
// directed vector table plus hand-written reset and periodic sequences.
module tb_counter_ctrl;

  localparam int W  = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          periodic;
  logic [W-1:0]  start_val;
  logic [W-1:0]  end_val;
  logic [W-1:0]  count;
  logic [W-1:0]  load;
  logic          le;
  logic          ce;
  logic          busy;
  logic          tick;
  logic [RW-1:0] runs;

  always #5 clk = ~clk;

  counter_ctrl #(.W(W), .RUNS_W(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .start_val (start_val),
    .end_val   (end_val),
    .count     (count),
    .load      (load),
    .le        (le),
    .ce        (ce),
    .busy      (busy),
    .tick      (tick),
    .runs      (runs)
  );

  // Registered loadable up-counter fed back into the sequencer.
  always @(posedge clk) begin
    if (reset)   count <= '0;
    else if (le) count <= load;
    else if (ce) count <= count + 8'd1;
  end

  typedef struct {
    logic          st;
    logic          sp;
    logic          per;
    logic [W-1:0]  sv;
    logic [W-1:0]  ev;
    logic          le;
    logic          ce;
    logic          busy;
    logic          tick;
    logic [W-1:0]  cnt;
    logic [RW-1:0] runs;
    logic [W-1:0]  ld;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic st, input logic sp, input logic per,
                              input logic [W-1:0] sv, input logic [W-1:0] ev,
                              input logic e_le, input logic e_ce, input logic e_busy,
                              input logic e_tick, input logic [W-1:0] e_cnt,
                              input logic [RW-1:0] e_runs, input logic [W-1:0] e_ld);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.sv = sv; v.ev = ev;
    v.le = e_le; v.ce = e_ce; v.busy = e_busy; v.tick = e_tick;
    v.cnt = e_cnt; v.runs = e_runs; v.ld = e_ld;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", name, step, act, exp);
    end
  endtask

  initial begin
    int p;
    reset = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    start_val = '0; end_val = '0;

    // One-shot 13->16: tick in cycle 6, then IDLE with runs=1.
    add(1,0,0, 13,16,  1,0,1,0, 16'd0 , 0, 13);
    add(0,0,0, 13,16,  0,1,1,0, 13, 0, 13);
    add(0,0,0, 13,16,  0,1,1,0, 14, 0, 13);
    add(0,0,0, 13,16,  0,1,1,0, 15, 0, 13);
    add(0,0,0, 13,16,  0,0,1,0, 16, 0, 13);
    add(0,0,0, 13,16,  0,0,1,1, 16, 0, 13);
    add(0,0,0, 13,16,  0,0,0,0, 16, 1, 13);
    // Stop while count=15 in a 13->20 run: IDLE next, count frozen at 16, no tick.
    add(1,0,0, 13,20,  1,0,1,0, 16, 0, 13);
    add(0,0,0, 13,20,  0,1,1,0, 13, 0, 13);
    add(0,0,0, 13,20,  0,1,1,0, 14, 0, 13);
    add(0,0,0, 13,20,  0,1,1,0, 15, 0, 13);
    add(0,1,0, 13,20,  0,0,0,0, 16, 0, 13);
    add(0,0,0, 13,20,  0,0,0,0, 16, 0, 13);
    add(0,0,0, 13,20,  0,0,0,0, 16, 0, 13);
    // start_val == end_val: zero increments, tick in cycle 3.
    add(1,0,0, 7,7,    1,0,1,0, 16, 0, 7);
    add(0,0,0, 7,7,    0,0,1,0, 7,  0, 7);
    add(0,0,0, 7,7,    0,0,1,1, 7,  0, 7);
    add(0,0,0, 7,7,    0,0,0,0, 7,  1, 7);
    // Wrap 254->1: 254,255,0,1 and tick in cycle 6.
    add(1,0,0, 254,1,  1,0,1,0, 7,   0, 254);
    add(0,0,0, 254,1,  0,1,1,0, 254, 0, 254);
    add(0,0,0, 254,1,  0,1,1,0, 255, 0, 254);
    add(0,0,0, 254,1,  0,1,1,0, 0,   0, 254);
    add(0,0,0, 254,1,  0,0,1,0, 1,   0, 254);
    add(0,0,0, 254,1,  0,0,1,1, 1,   0, 254);
    add(0,0,0, 254,1,  0,0,0,0, 1,   1, 254);
    // start with new values mid-run is ignored; the run finishes on the old values.
    add(1,0,0, 13,16,   1,0,1,0, 1,  0, 13);
    add(1,0,1, 100,200, 0,1,1,0, 13, 0, 13);
    add(1,0,1, 100,200, 0,1,1,0, 14, 0, 13);
    add(0,0,0, 100,200, 0,1,1,0, 15, 0, 13);
    add(0,0,0, 100,200, 0,0,1,0, 16, 0, 13);
    add(0,0,0, 100,200, 0,0,1,1, 16, 0, 13);
    add(0,0,0, 100,200, 0,0,0,0, 16, 1, 13);
    // start and stop together in IDLE: stays IDLE, nothing captured.
    add(1,1,0, 50,60,  0,0,0,0, 16, 1, 13);
    add(0,0,0, 50,60,  0,0,0,0, 16, 1, 13);

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_le",   i, le,   0);
      chk("rst_ce",   i, ce,   0);
      chk("rst_tick", i, tick, 0);
      chk("rst_busy", i, busy, 0);
      chk("rst_runs", i, runs, 0);
      chk("rst_load", i, load, 0);
      $display("reset cycle %0d: le=%0b ce=%0b busy=%0b runs=%0d", i, le, ce, busy, runs);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 0, busy, 0);
    chk("idle_le",   0, le,   0);

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; periodic = vecs[i].per;
      start_val = vecs[i].sv; end_val = vecs[i].ev;
      @(posedge clk); #1;
      chk("le",    i, le,    vecs[i].le);
      chk("ce",    i, ce,    vecs[i].ce);
      chk("busy",  i, busy,  vecs[i].busy);
      chk("tick",  i, tick,  vecs[i].tick);
      chk("count", i, count, vecs[i].cnt);
      chk("runs",  i, runs,  vecs[i].runs);
      chk("load",  i, load,  vecs[i].ld);
      $display("vec %0d: st=%0b sp=%0b le=%0b ce=%0b busy=%0b tick=%0b count=%0d runs=%0d",
               i, vecs[i].st, vecs[i].sp, le, ce, busy, tick, count, runs);
    end

    // Periodic 2->4: LOAD every 5 cycles, runs=3 after the third tick.
    start = 1'b1; stop = 1'b0; periodic = 1'b1; start_val = 8'd2; end_val = 8'd4;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      p = (c - 1) % 5;
      chk("per_le",   c, le,   (p == 0) ? 1 : 0);
      chk("per_ce",   c, ce,   (p == 1 || p == 2) ? 1 : 0);
      chk("per_tick", c, tick, (p == 4) ? 1 : 0);
      chk("per_busy", c, busy, 1);
      chk("per_runs", c, runs, (c - 1) / 5);
      if (p != 0) chk("per_count", c, count, (p == 4) ? 4 : p + 1);
      $display("periodic cycle %0d: le=%0b ce=%0b tick=%0b count=%0d runs=%0d",
               c, le, ce, tick, count, runs);
    end
    // Stop during LOAD: the load still happens, then IDLE with runs held.
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("pstop_busy",  0, busy,  0);
    chk("pstop_le",    0, le,    0);
    chk("pstop_count", 0, count, 2);
    chk("pstop_runs",  0, runs,  3);
    @(posedge clk); #1;
    chk("pstop_hold",  1, count, 2);
    chk("pstop_idle",  1, busy,  0);
    $display("periodic stop: busy=%0b count=%0d runs=%0d", busy, count, runs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
